muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 202 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative integer multiply/divide unit for a RISC-V style
// EX stage. Multiply is radix-2 shift-add over a 2*XLEN product; divide is
// radix-2 restoring division. Both work on operand magnitudes, and the sign
// is fixed up in a single cycle at the end.
//
// Ports
//   clk_i     single clock, rising edge
//   rst_i     asynchronous reset, active low
//   start_i   request a new operation (ignored while busy)
//   op_i      funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU,
//             4 DIV, 5 DIVU, 6 REM, 7 REMU
//   rs1_i     multiplicand / dividend
//   rs2_i     multiplier / divisor
//   flush_i   abort any operation in flight
//   busy_o    high while computing (CALC, FIX)
//   done_o    one-cycle result-valid pulse (DONE)
//   result_o  result, held until a later operation completes
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i
// CALC  | one radix-2 step per cycle, XLEN cycles, counter counts down
// FIX   | sign correction and selection of the result word
// DONE  | result valid; a new start may be accepted here (back-to-back)
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [XLEN-1:0] hi;       // product high half / partial remainder
    logic [XLEN-1:0] lo;       // product low half + multiplier / dividend -> quotient
    logic [XLEN-1:0] opb;      // multiplicand magnitude / divisor magnitude
    logic            neg_q;    // negate product or quotient
    logic            neg_r;    // negate remainder (dividend sign)
    logic [XLEN-1:0] result;

    // Operand decode on the request side.
    logic            accept;
    logic            sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf, bypass;
    logic [XLEN-1:0] bypass_res;

    always_comb begin
        accept = ((state_q == IDLE) || (state_q == DONE)) && start_i && !flush_i;
        sgn1   = op_i[2] ? ~op_i[0] : ((op_i[1:0] == 2'b01) || (op_i[1:0] == 2'b10));
        sgn2   = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01);
        neg1   = sgn1 & rs1_i[XLEN-1];
        neg2   = sgn2 & rs2_i[XLEN-1];
        mag1   = neg1 ? -rs1_i : rs1_i;
        mag2   = neg2 ? -rs2_i : rs2_i;

        div_zero = op_i[2] && (rs2_i == '0);
        div_ovf  = op_i[2] && !op_i[0] && (rs1_i == MOST_NEG) && (rs2_i == '1);
        bypass   = div_zero || div_ovf;

        // op_i[1] selects remainder among the divide codes.
        if (div_zero) begin
            bypass_res = op_i[1] ? rs1_i : '1;
        end else begin
            bypass_res = op_i[1] ? '0 : rs1_i;
        end
    end

    // One iteration step for the operation in flight.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_sub;
    logic [XLEN-1:0] hi_step, lo_step;

    always_comb begin
        mul_sum   = {1'b0, hi} + {1'b0, opb};
        div_shift = {hi, lo[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opb});
        // When div_ge holds the true difference is below 2^XLEN, so the
        // narrow subtraction is exact.
        div_sub   = div_shift[XLEN-1:0] - opb;
        hi_step   = hi;
        lo_step   = lo;
        if (op_q[2]) begin
            hi_step = div_ge ? div_sub : div_shift[XLEN-1:0];
            lo_step = {lo[XLEN-2:0], div_ge};
        end else if (lo[0]) begin
            {hi_step, lo_step} = {mul_sum, lo[XLEN-1:1]};
        end else begin
            {hi_step, lo_step} = {1'b0, hi, lo[XLEN-1:1]};
        end
    end

    // Sign correction and result selection.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, fix_res;

    always_comb begin
        prod_fix = neg_q ? -{hi, lo} : {hi, lo};
        q_fix    = neg_q ? -lo : lo;
        r_fix    = neg_r ? -hi : hi;
        if (op_q[2]) begin
            fix_res = op_q[1] ? r_fix : q_fix;
        end else if (op_q[1:0] == 2'b00) begin
            fix_res = prod_fix[XLEN-1:0];
        end else begin
            fix_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = bypass ? DONE : CALC;
            end
            CALC: begin
                busy_o = 1'b1;
                if (cnt == CW'(1)) state_d = FIX;
            end
            FIX: begin
                busy_o  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done_o = 1'b1;
                if (accept) state_d = bypass ? DONE : CALC;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt    <= '0;
            op_q   <= '0;
            hi     <= '0;
            lo     <= '0;
            opb    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else if (flush_i) begin
            cnt <= '0;
        end else if (accept) begin
            op_q  <= op_i;
            neg_q <= neg1 ^ neg2;
            neg_r <= neg1;
            if (bypass) begin
                result <= bypass_res;
            end else begin
                cnt <= CNT_LOAD;
                hi  <= '0;
                lo  <= op_i[2] ? mag1 : mag2;
                opb <= op_i[2] ? mag2 : mag1;
            end
        end else if (state_q == CALC) begin
            hi  <= hi_step;
            lo  <= lo_step;
            cnt <= cnt - CW'(1);
        end else if (state_q == FIX) begin
            result <= fix_res;
        end
    end

    assign result_o = result;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    int vectors     = 0;
    int miscompares = 0;
    logic [XLEN-1:0] exp_q[$];

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model built from native 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        model = '0;
        case (op)
            3'd0: begin p = ua * ub; model = p[31:0]; end
            3'd1: begin p = sa * sb; model = p[63:32]; end
            3'd2: begin p = sa * $signed(ub); model = p[63:32]; end
            3'd3: begin p = ua * ub; model = p[63:32]; end
            3'd4: if (b == 0) model = '1; else begin p = sa / sb; model = p[31:0]; end
            3'd5: if (b == 0) model = '1; else model = a / b;
            3'd6: if (b == 0) model = a;  else begin p = sa % sb; model = p[31:0]; end
            default: if (b == 0) model = a; else model = a % b;
        endcase
    endfunction

    // Issue one operation from the current (post-edge) time, track latency and
    // busy cycles, and compare the result popped from the scoreboard.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input bit idle_after);
        int edges;
        int busy_cnt;
        logic [31:0] e;
        exp_q.push_back(exp);
        start_i = 1'b1;
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        @(posedge clk_i); #1;
        start_i  = 1'b0;
        op_i     = 3'($urandom_range(0, 7));
        rs1_i    = $urandom;
        rs2_i    = $urandom;
        edges    = 1;
        busy_cnt = 0;
        while (!done_o && edges < 100) begin
            if (busy_o) busy_cnt++;
            @(posedge clk_i); #1;
            edges++;
        end
        check({tag, "_latency"}, 64'(edges), 64'(lat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(lat - 1));
        e = exp_q.pop_front();
        check({tag, "_result"}, 64'(result_o), 64'(e));
        if (idle_after) begin
            @(posedge clk_i); #1;
            check({tag, "_done_pulse"}, 64'(done_o), 64'(0));
            check({tag, "_idle_busy"}, 64'(busy_o), 64'(0));
            check({tag, "_hold"}, 64'(result_o), 64'(e));
        end
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] a, b;
        logic [2:0]  op;
        int          lat;
        int          seen;

        rst_i   = 1'b1;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = '0;
        rs1_i   = '0;
        rs2_i   = '0;
        #2 rst_i = 1'b0;
        #1;
        check("reset_busy", 64'(busy_o), 64'(0));
        check("reset_done", 64'(done_o), 64'(0));
        check("reset_result", 64'(result_o), 64'(0));
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_i = 1'b1;
        @(posedge clk_i); #1;

        do_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b1);
        do_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b1);
        do_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b1);
        do_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 1'b1);
        do_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b1);
        do_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1'b1);
        do_op("divu_z",  3'd5, 32'h1234, 32'd0, 32'hFFFFFFFF, 1, 1'b1);
        do_op("remu_z",  3'd7, 32'h1234, 32'd0, 32'h00001234, 1, 1'b1);
        do_op("rem_neg", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 1'b0);
        do_op("div_b2b", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 1'b1);
        do_op("div_pn",  3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34, 1'b1);
        do_op("rem_pn",  3'd6, 32'd7, 32'hFFFFFFFE, 32'h00000001, 34, 1'b1);
        do_op("divu",    3'd5, 32'd100, 32'd7, 32'h0000000E, 34, 1'b1);

        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 3 == 0) ? $urandom_range(0, 3) : $urandom;
            lat = (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
                  ? 1 : 34;
            do_op("rand", op, a, b, model(op, a, b), lat, 1'b1);
        end

        // Flush at CALC cycle 5.
        prev    = result_o;
        start_i = 1'b1;
        op_i    = 3'd0;
        rs1_i   = 32'd5;
        rs2_i   = 32'd6;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (4) begin @(posedge clk_i); #1; end
        check("flush_busy_calc", 64'(busy_o), 64'(1));
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("flush_busy", 64'(busy_o), 64'(0));
        check("flush_done", 64'(done_o), 64'(0));
        check("flush_result", 64'(result_o), 64'(prev));
        seen = 0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (done_o) seen++;
        end
        check("flush_no_done", 64'(seen), 64'(0));

        // Flush wins over a simultaneous start.
        start_i = 1'b1;
        flush_i = 1'b1;
        op_i    = 3'd5;
        rs1_i   = 32'd9;
        rs2_i   = 32'd0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        check("flush_start_busy", 64'(busy_o), 64'(0));
        check("flush_start_done", 64'(done_o), 64'(0));
        check("flush_start_result", 64'(result_o), 64'(prev));

        // Reset asserted mid-CALC.
        start_i = 1'b1;
        op_i    = 3'd5;
        rs1_i   = 32'd1000;
        rs2_i   = 32'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (4) begin @(posedge clk_i); #1; end
        rst_i = 1'b0;
        #2;
        check("rst_mid_busy", 64'(busy_o), 64'(0));
        check("rst_mid_done", 64'(done_o), 64'(0));
        check("rst_mid_result", 64'(result_o), 64'(0));
        @(negedge clk_i) rst_i = 1'b1;
        @(posedge clk_i); #1;
        do_op("after_rst", 3'd5, 32'd1000, 32'd3, 32'd333, 34, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
